// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// One pipeline stage with a valid/ready handshake, backed by a two-entry skid
// buffer. in_ready is a flop, so back-pressure from out_ready never forms a
// combinational path to the upstream stage. Under continuous flow the stage
// moves one transfer per cycle. A synchronous flush empties the stage.
//
// Parameters
//   WIDTH      : payload width in bits.
//   CLEAR_DATA : 1 = flush also zeroes both data registers.
//                0 = flush clears only the valid state; data holds.
//
// Ports
//   clk       : clock; all state updates on the rising edge.
//   rst       : asynchronous, active-high reset.
//   flush     : synchronous clear; the stage is empty on the next cycle.
//   in_valid  : upstream presents in_data.
//   in_ready  : stage can accept a beat (registered).
//   in_data   : upstream payload.
//   out_valid : stage presents out_data (registered).
//   out_ready : downstream accepts.
//   out_data  : payload at the head of the stage (registered).
//   level     : occupancy, 0/1/2 (registered).
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int WIDTH      = 32,
    parameter int CLEAR_DATA = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    // Encoding doubles as the occupancy count, so level is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   main_q,      main_d;
    logic [WIDTH-1:0]   skid_q,      skid_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               in_fire;
    logic               out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Anything accepted this cycle is dropped; a beat that leaves this
            // cycle is simply not re-presented because the stage goes empty.
            state_d = ST_EMPTY;
            if (CLEAR_DATA != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    // out_valid is high in ONE, so !out_fire means !out_ready.
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Handshake outputs are computed from the next state and registered,
        // keeping out_ready out of any combinational path to in_ready.
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state, so every flop
            // samples the values from before this edge.
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign level     = state_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
//
// Four instances share one stimulus: the default stage (WIDTH=32,
// CLEAR_DATA=1), a CLEAR_DATA=0 variant, and WIDTH=1 / WIDTH=64 variants.
// A queue scoreboard holds accepted beats; its size gives the expected
// handshake and level, and its head gives the expected out_data.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    // Default instance
    logic        in_ready,  out_valid;
    logic [31:0] out_data;
    logic [1:0]  level;
    // CLEAR_DATA = 0
    logic        nc_in_ready, nc_out_valid;
    logic [31:0] nc_out_data;
    logic [1:0]  nc_level;
    // WIDTH = 1
    logic        w1_in_ready, w1_out_valid;
    logic [0:0]  w1_out_data;
    logic [1:0]  w1_level;
    // WIDTH = 64
    logic        w64_in_ready, w64_out_valid;
    logic [63:0] w64_out_data;
    logic [1:0]  w64_level;

    logic [0:0]  w1_in_data;
    logic [63:0] w64_in_data;
    assign w1_in_data  = in_data[0:0];
    assign w64_in_data = {in_data, in_data};

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(32), .CLEAR_DATA(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level)
    );

    pipe_skid_stage #(.WIDTH(32), .CLEAR_DATA(0)) dut_nc (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(nc_in_ready), .in_data(in_data),
        .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data),
        .level(nc_level)
    );

    pipe_skid_stage #(.WIDTH(1), .CLEAR_DATA(1)) dut_w1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(w1_in_ready), .in_data(w1_in_data),
        .out_valid(w1_out_valid), .out_ready(out_ready), .out_data(w1_out_data),
        .level(w1_level)
    );

    pipe_skid_stage #(.WIDTH(64), .CLEAR_DATA(1)) dut_w64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(w64_in_ready), .in_data(w64_in_data),
        .out_valid(w64_out_valid), .out_ready(out_ready), .out_data(w64_out_data),
        .level(w64_level)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard and reference state.
    logic [31:0] sb[$];
    logic [31:0] exp_main;     // head register of the CLEAR_DATA=1 stages
    logic [31:0] exp_main_nc;  // head register of the CLEAR_DATA=0 stage

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] e_lvl;
        logic       e_ov, e_ir;
        e_lvl = 2'(sb.size());
        e_ov  = (sb.size() != 0);
        e_ir  = (sb.size() != 2);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
        check({tag, ".in_ready"},  64'(in_ready),  64'(e_ir));
        check({tag, ".level"},     64'(level),     64'(e_lvl));
        check({tag, ".out_data"},  64'(out_data),  64'(exp_main));
        check({tag, ".nc_hs"},     64'({nc_out_valid, nc_in_ready, nc_level}),
                                   64'({e_ov, e_ir, e_lvl}));
        check({tag, ".nc_data"},   64'(nc_out_data), 64'(exp_main_nc));
        check({tag, ".w1_hs"},     64'({w1_out_valid, w1_in_ready, w1_level}),
                                   64'({e_ov, e_ir, e_lvl}));
        check({tag, ".w1_data"},   64'(w1_out_data), 64'(exp_main[0]));
        check({tag, ".w64_hs"},    64'({w64_out_valid, w64_in_ready, w64_level}),
                                   64'({e_ov, e_ir, e_lvl}));
        check({tag, ".w64_data"},  w64_out_data, {exp_main, exp_main});
    endtask

    // One clock cycle: drive inputs after the falling edge, update the
    // reference at the rising edge, compare 1 time unit later.
    task automatic step(input string tag, input bit v, input logic [31:0] d,
                        input bit ordy, input bit fl);
        bit m_in_rdy, m_out_vld, in_f, out_f;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        m_in_rdy  = (sb.size() != 2);
        m_out_vld = (sb.size() != 0);
        in_f      = v && m_in_rdy;
        out_f     = m_out_vld && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            exp_main = '0;
        end else begin
            if (out_f) void'(sb.pop_front());
            if (in_f)  sb.push_back(d);
            if (sb.size() != 0) begin
                exp_main    = sb[0];
                exp_main_nc = sb[0];
            end
        end
        check_all(tag);
    endtask

    task automatic do_reset_sync();
        rst = 1'b1;
        sb.delete();
        exp_main    = '0;
        exp_main_nc = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        do_reset_sync();
        #1;
        check_all("reset");

        // Streaming: one-cycle latency, level stays 1, in_ready stays 1.
        step("stream0", 1, 32'h11, 1, 0);
        step("stream1", 1, 32'h22, 1, 0);
        step("stream2", 1, 32'h33, 1, 0);
        step("stream_drain", 0, 32'h0, 1, 0);

        // Back-pressure: fill to two entries, then pop both.
        step("bp_a", 1, 32'hA, 0, 0);
        step("bp_b", 1, 32'hB, 0, 0);
        step("bp_hold", 1, 32'hD, 0, 0);
        step("bp_pop_a", 0, 32'h0, 1, 0);
        step("bp_pop_b", 0, 32'h0, 1, 0);
        step("bp_empty", 0, 32'h0, 1, 0);

        // Flush while FULL with an accepted-looking input: 0xC must never show.
        step("fl_a", 1, 32'hA, 0, 0);
        step("fl_b", 1, 32'hB, 0, 0);
        step("flush", 1, 32'hC, 0, 1);
        step("fl_after", 0, 32'h0, 1, 0);
        check("flush.nc_holds_a", 64'(nc_out_data), 64'h0000_000A);
        check("flush.clear_zero", 64'(out_data), 64'h0);

        // Asynchronous reset mid-cycle while FULL: outputs change with no edge.
        step("rs_a", 1, 32'h5A, 0, 0);
        step("rs_b", 1, 32'h5B, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.out_valid", 64'(out_valid), 64'h0);
        check("async_rst.level",     64'(level),     64'h0);
        check("async_rst.in_ready",  64'(in_ready),  64'h1);
        check("async_rst.out_data",  64'(out_data),  64'h0);
        do_reset_sync();
        #1;
        check_all("post_rst");

        // Random stress with about 2% flush.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 bit'($urandom_range(0, 1)),
                 $urandom(),
                 bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 2));
        end

        // Drain whatever is left.
        for (int i = 0; i < 3; i++) step("drain", 0, 32'h0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
